// File: rtl/keypad_scanner.sv
// Column-scanning front end for a 4x4 encoded keypad: synchronizes the encoder
// outputs, debounces press and release, and emits one strobe per accepted key.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 1500,
    parameter int unsigned DEBOUNCE_CYCLES = 15000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] row_result,
    input  logic       valid_out,
    output logic [1:0] col_selector,
    output logic [3:0] key_code,
    output logic       key_strobe,
    output logic       key_held
);

    localparam int unsigned CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEB_PRESS,
        ST_HELD,
        ST_DEB_REL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       cand_row_q, cand_row_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_strobe_q, key_strobe_d;
    logic             key_held_q, key_held_d;

    logic [1:0]       row_meta_q, row_s_q;
    logic             valid_meta_q, valid_s_q;

    logic             press_match_c;
    logic             accept_c;
    logic             release_done_c;

    // Two-flop synchronizer for the asynchronous keypad pins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_meta_q   <= 2'd0;
            row_s_q      <= 2'd0;
            valid_meta_q <= 1'b0;
            valid_s_q    <= 1'b0;
        end else begin
            row_meta_q   <= row_result;
            row_s_q      <= row_meta_q;
            valid_meta_q <= valid_out;
            valid_s_q    <= valid_meta_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_SCAN;
            cnt_q        <= '0;
            col_q        <= 2'd0;
            cand_row_q   <= 2'd0;
            key_code_q   <= 4'd0;
            key_strobe_q <= 1'b0;
            key_held_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            col_q        <= col_d;
            cand_row_q   <= cand_row_d;
            key_code_q   <= key_code_d;
            key_strobe_q <= key_strobe_d;
            key_held_q   <= key_held_d;
        end
    end

    // Shared transition qualifiers used by both combinational processes.
    assign press_match_c  = valid_s_q && (row_s_q == cand_row_q);
    assign accept_c       = (state_q == ST_DEB_PRESS) && press_match_c && (cnt_q == DEB_LAST);
    assign release_done_c = (state_q == ST_DEB_REL) && !valid_s_q && (cnt_q == DEB_LAST);

    // Next-state, dwell/debounce counter, column and candidate row.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        col_d      = col_q;
        cand_row_d = cand_row_q;
        unique case (state_q)
            ST_SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (valid_s_q) begin
                        cand_row_d = row_s_q;
                        state_d    = ST_DEB_PRESS;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DEB_PRESS: begin
                if (!press_match_c) begin
                    // Same column is resampled after a full dwell.
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_HELD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HELD: begin
                cnt_d = '0;
                if (!valid_s_q) begin
                    state_d = ST_DEB_REL;
                end
            end
            ST_DEB_REL: begin
                if (valid_s_q) begin
                    cnt_d   = '0;
                    state_d = ST_HELD;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d   = '0;
                    col_d   = col_q + 2'd1;
                    state_d = ST_SCAN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_SCAN;
            end
        endcase
    end

    // Registered key outputs; key_code only moves on an accepted press.
    always_comb begin
        key_code_d   = key_code_q;
        key_strobe_d = 1'b0;
        key_held_d   = key_held_q;
        if (accept_c) begin
            key_code_d   = {col_q, cand_row_q};
            key_strobe_d = 1'b1;
            key_held_d   = 1'b1;
        end else if (release_done_c) begin
            key_held_d = 1'b0;
        end
    end

    assign col_selector = col_q;
    assign key_code     = key_code_q;
    assign key_strobe   = key_strobe_q;
    assign key_held     = key_held_q;

endmodule
